// File: rtl/led_sweep_ctrl_pkg.sv
// rtl/led_sweep_ctrl_pkg.sv - shared types and constants for the LED sweep sequencer
package led_sweep_ctrl_pkg;

   localparam int PAT_W = 7;

   localparam logic [PAT_W-1:0] HOME_DEFAULT = 7'b0001000;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SWEEP_L = 2'd1,
      SWEEP_R = 2'd2
   } state_t;

endpackage

// File: rtl/led_sweep_ctrl_tick_gen.sv
// rtl/led_sweep_ctrl_tick_gen.sv - step prescaler, one tick every DIV enabled cycles
module led_sweep_ctrl_tick_gen #(
   parameter int DIV = 50
) (
   input  logic clk,
   input  logic Reset,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam int PW = $clog2(DIV);
   localparam logic [PW-1:0] LAST = PW'(DIV - 1);

   logic [PW-1:0] r_presc;

   always_ff @(posedge clk) begin
      if (Reset) begin
         r_presc <= '0;
      end else if (clr) begin
         r_presc <= '0;
      end else if (en) begin
         if (tick) begin
            r_presc <= '0;
         end else begin
            r_presc <= r_presc + 1'b1;
         end
      end
   end

   assign tick = (r_presc == LAST);

endmodule

// File: rtl/led_sweep_ctrl.sv
// rtl/led_sweep_ctrl.sv - L/R sweep sequencer driving the 7-bit LED pattern
module led_sweep_ctrl
   import led_sweep_ctrl_pkg::*;
#(
   parameter int               DIV     = 50,
   parameter int               RUN_LEN = 3,
   parameter logic [PAT_W-1:0] HOME    = HOME_DEFAULT
) (
   input  logic             clk,
   input  logic             Reset,
   input  logic             L,
   input  logic             R,
   output logic [PAT_W-1:0] S,
   output logic             busy,
   output logic             dir,
   output logic             step,
   output logic             done,
   output logic             conflict
);

   localparam int CW = $clog2(RUN_LEN + 1);
   localparam logic [CW-1:0] RUN_LEN_C = CW'(RUN_LEN);

   state_t           r_state;
   state_t           w_state_nxt;
   logic             r_l_q;
   logic             r_r_q;
   logic [PAT_W-1:0] r_s;
   logic [PAT_W-1:0] w_s_nxt;
   logic [CW-1:0]    r_cnt;
   logic [CW-1:0]    w_cnt_nxt;
   logic             r_busy;
   logic             w_busy_nxt;
   logic             r_dir;
   logic             w_dir_nxt;
   logic             r_step;
   logic             w_step_nxt;
   logic             r_done;
   logic             w_done_nxt;
   logic             r_conflict;
   logic             w_conflict_nxt;
   logic             w_lr;
   logic             w_rr;
   logic             w_clr;
   logic             w_tick;

   // Delayed copies reset high so a button held through reset is not a request.
   always_ff @(posedge clk) begin
      if (Reset) begin
         r_l_q <= 1'b1;
         r_r_q <= 1'b1;
      end else begin
         r_l_q <= L;
         r_r_q <= R;
      end
   end

   assign w_lr = L & ~r_l_q;
   assign w_rr = R & ~r_r_q;

   led_sweep_ctrl_tick_gen #(
      .DIV (DIV)
   ) u_tick_gen (
      .clk   (clk),
      .Reset (Reset),
      .clr   (w_clr),
      .en    (r_busy),
      .tick  (w_tick)
   );

   always_comb begin
      w_state_nxt    = r_state;
      w_s_nxt        = r_s;
      w_cnt_nxt      = r_cnt;
      w_dir_nxt      = r_dir;
      w_step_nxt     = 1'b0;
      w_done_nxt     = 1'b0;
      w_conflict_nxt = 1'b0;
      w_clr          = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_lr || w_rr) begin
               w_clr     = 1'b1;
               w_cnt_nxt = '0;
               if (w_lr && w_rr) begin
                  w_conflict_nxt = 1'b1;
               end else if (w_lr) begin
                  w_state_nxt = SWEEP_L;
                  w_dir_nxt   = 1'b1;
               end else begin
                  w_state_nxt = SWEEP_R;
                  w_dir_nxt   = 1'b0;
               end
            end
         end
         SWEEP_L, SWEEP_R: begin
            if (w_tick) begin
               if (r_cnt < RUN_LEN_C) begin
                  // Rotation wraps end-around; there is no saturation.
                  if (r_state == SWEEP_L) begin
                     w_s_nxt = {r_s[PAT_W-2:0], r_s[PAT_W-1]};
                  end else begin
                     w_s_nxt = {r_s[0], r_s[PAT_W-1:1]};
                  end
                  w_cnt_nxt  = r_cnt + 1'b1;
                  w_step_nxt = 1'b1;
               end else begin
                  w_s_nxt     = HOME;
                  w_state_nxt = IDLE;
                  w_done_nxt  = 1'b1;
               end
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
      w_busy_nxt = (w_state_nxt != IDLE);
   end

   always_ff @(posedge clk) begin
      if (Reset) begin
         r_state    <= IDLE;
         r_s        <= HOME;
         r_cnt      <= '0;
         r_busy     <= 1'b0;
         r_dir      <= 1'b0;
         r_step     <= 1'b0;
         r_done     <= 1'b0;
         r_conflict <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_s        <= w_s_nxt;
         r_cnt      <= w_cnt_nxt;
         r_busy     <= w_busy_nxt;
         r_dir      <= w_dir_nxt;
         r_step     <= w_step_nxt;
         r_done     <= w_done_nxt;
         r_conflict <= w_conflict_nxt;
      end
   end

   assign S        = r_s;
   assign busy     = r_busy;
   assign dir      = r_dir;
   assign step     = r_step;
   assign done     = r_done;
   assign conflict = r_conflict;

endmodule

// File: tb/tb_led_sweep_ctrl.sv
// tb/tb_led_sweep_ctrl.sv - randomized and directed bench against a time-based sweep model
module tb_led_sweep_ctrl;

   localparam int DIV = 4;
   localparam logic [6:0] HOME = 7'b0001000;

   logic clk;
   logic Reset;
   logic L;
   logic R;

   logic [6:0] s0, s1;
   logic       busy0, busy1, dir0, dir1, step0, step1, done0, done1, conf0, conf1;

   int n_checks = 0;
   int n_errors = 0;

   led_sweep_ctrl #(.DIV(DIV), .RUN_LEN(3), .HOME(HOME)) dut (
      .clk(clk), .Reset(Reset), .L(L), .R(R),
      .S(s0), .busy(busy0), .dir(dir0), .step(step0), .done(done0), .conflict(conf0)
   );

   led_sweep_ctrl #(.DIV(DIV), .RUN_LEN(4), .HOME(HOME)) dut4 (
      .clk(clk), .Reset(Reset), .L(L), .R(R),
      .S(s1), .busy(busy1), .dir(dir1), .step(step1), .done(done1), .conflict(conf1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference: a sweep is "elapsed cycles since accept"; pattern follows from that count.
   int         rl[2] = '{3, 4};
   logic [6:0] m_s[2];
   bit         m_busy[2], m_dir[2], m_step[2], m_done[2], m_conf[2];
   int         m_t[2];
   bit         m_pl, m_pr;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [6:0] rot(input logic [6:0] p, input int k, input bit left);
      logic [6:0] v;
      v = p;
      for (int j = 0; j < k; j++) begin
         v = left ? {v[5:0], v[6]} : {v[0], v[6:1]};
      end
      return v;
   endfunction

   task automatic model_step(input bit l, input bit r, input bit rst);
      bit lr, rr;
      int k;
      if (rst) begin
         for (int i = 0; i < 2; i++) begin
            m_s[i] = HOME; m_busy[i] = 0; m_dir[i] = 0;
            m_step[i] = 0; m_done[i] = 0; m_conf[i] = 0; m_t[i] = 0;
         end
         m_pl = 1; m_pr = 1;
         return;
      end
      lr = l && !m_pl;
      rr = r && !m_pr;
      m_pl = l;
      m_pr = r;
      for (int i = 0; i < 2; i++) begin
         m_step[i] = 0; m_done[i] = 0; m_conf[i] = 0;
         if (m_busy[i]) begin
            m_t[i]++;
            if (m_t[i] % DIV == 0) begin
               k = m_t[i] / DIV;
               if (k <= rl[i]) begin
                  m_s[i] = rot(HOME, k, m_dir[i]);
                  m_step[i] = 1;
               end else begin
                  m_s[i] = HOME;
                  m_done[i] = 1;
                  m_busy[i] = 0;
               end
            end
         end else if (lr && rr) begin
            m_conf[i] = 1;
         end else if (lr || rr) begin
            m_busy[i] = 1;
            m_t[i] = 0;
            m_dir[i] = lr;
         end
      end
   endtask

   task automatic cmp_one(input int i, input logic [6:0] s, input logic b, input logic d,
                          input logic st, input logic dn, input logic cf);
      check($sformatf("u%0d_S", i), 32'(s), 32'(m_s[i]));
      check($sformatf("u%0d_busy", i), 32'(b), 32'(m_busy[i]));
      check($sformatf("u%0d_dir", i), 32'(d), 32'(m_dir[i]));
      check($sformatf("u%0d_step", i), 32'(st), 32'(m_step[i]));
      check($sformatf("u%0d_done", i), 32'(dn), 32'(m_done[i]));
      check($sformatf("u%0d_conflict", i), 32'(cf), 32'(m_conf[i]));
   endtask

   task automatic cyc(input bit l, input bit r, input bit rst);
      L = l;
      R = r;
      Reset = rst;
      model_step(l, r, rst);
      @(negedge clk);
      cmp_one(0, s0, busy0, dir0, step0, done0, conf0);
      cmp_one(1, s1, busy1, dir1, step1, done1, conf1);
   endtask

   bit rl_v, rr_v, rst_v;

   initial begin
      L = 0; R = 0; Reset = 1;

      cyc(0, 0, 1);
      cyc(0, 0, 1);
      check("rst_S", 32'(s0), 32'(HOME));
      check("rst_busy", 32'(busy0), 0);
      cyc(0, 0, 0);

      // Left sweep
      cyc(1, 0, 0);
      repeat (4) cyc(0, 0, 0);
      check("t2_s4", 32'(s0), 32'(7'b0010000));
      repeat (11) cyc(0, 0, 0);
      cyc(0, 0, 0);
      check("t2_home16", 32'(s0), 32'(HOME));
      check("t2_done16", 32'(done0), 1);
      repeat (6) cyc(0, 0, 0);

      // Right sweep
      cyc(0, 1, 0);
      check("t3_dir", 32'(dir0), 0);
      check("t3_busy", 32'(busy0), 1);
      repeat (12) cyc(0, 0, 0);
      check("t3_s12", 32'(s0), 32'(7'b0000001));
      repeat (8) cyc(0, 0, 0);

      // Simultaneous rise
      cyc(1, 1, 0);
      check("t4_conflict", 32'(conf0), 1);
      check("t4_busy", 32'(busy0), 0);
      cyc(0, 0, 0);
      check("t4_conflict_off", 32'(conf0), 0);
      cyc(0, 0, 0);

      // R during L sweep ignored
      cyc(1, 0, 0);
      repeat (4) cyc(0, 0, 0);
      cyc(0, 1, 0);
      repeat (3) cyc(0, 0, 0);
      check("t5_s8", 32'(s0), 32'(7'b0100000));
      check("t5_dir", 32'(dir0), 1);
      repeat (10) cyc(0, 0, 0);

      // Reset mid-sweep with L held
      cyc(1, 0, 0);
      repeat (8) cyc(1, 0, 0);
      cyc(1, 0, 1);
      check("t6_rst_S", 32'(s0), 32'(HOME));
      check("t6_rst_busy", 32'(busy0), 0);
      repeat (20) cyc(1, 0, 0);
      check("t6_no_resweep", 32'(busy0), 0);
      cyc(0, 0, 0);

      // RUN_LEN=4 right sweep wraps
      cyc(0, 1, 0);
      repeat (16) cyc(0, 0, 0);
      check("t7_wrap", 32'(s1), 32'(7'b1000000));
      repeat (4) cyc(0, 0, 0);
      check("t7_home", 32'(s1), 32'(HOME));
      check("t7_done", 32'(done1), 1);

      // Random traffic
      rl_v = 0; rr_v = 0;
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 7) == 0) rl_v = ~rl_v;
         if ($urandom_range(0, 7) == 0) rr_v = ~rr_v;
         if ($urandom_range(0, 15) == 0) begin
            rl_v = ~rl_v;
            rr_v = rl_v;
         end
         rst_v = ($urandom_range(0, 399) == 0);
         cyc(rl_v, rr_v, rst_v);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
